// File: rtl/axi2mem_if.sv
// AXI4 bus bundle used by axi2mem: the five channels with the fields a
// single-beat slave needs, plus Master/Slave modports.
interface AXI_BUS #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 16,
   parameter int AXI_USER_WIDTH = 10
);
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   logic                        aw_valid, aw_ready;

   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic                        w_valid, w_ready;

   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [1:0]                  b_resp;
   logic [AXI_USER_WIDTH-1:0]   b_user;
   logic                        b_valid, b_ready;

   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   logic                        ar_valid, ar_ready;

   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [1:0]                  r_resp;
   logic                        r_last;
   logic [AXI_USER_WIDTH-1:0]   r_user;
   logic                        r_valid, r_ready;

   modport Master (
      output aw_addr, aw_id, aw_len, aw_size, aw_valid, input aw_ready,
      output w_data, w_strb, w_last, w_valid, input w_ready,
      input  b_id, b_resp, b_user, b_valid, output b_ready,
      output ar_addr, ar_id, ar_len, ar_size, ar_valid, input ar_ready,
      input  r_data, r_id, r_resp, r_last, r_user, r_valid, output r_ready
   );

   modport Slave (
      input  aw_addr, aw_id, aw_len, aw_size, aw_valid, output aw_ready,
      input  w_data, w_strb, w_last, w_valid, output w_ready,
      output b_id, b_resp, b_user, b_valid, input b_ready,
      input  ar_addr, ar_id, ar_len, ar_size, ar_valid, output ar_ready,
      output r_data, r_id, r_resp, r_last, r_user, r_valid, input r_ready
   );
endinterface

// File: rtl/axi2mem.sv
// Single-beat AXI4 slave bridging to a 1-cycle-latency SRAM port.
// Define AXI2MEM_ERR_CHECK_EN to answer bursts / non-word sizes with SLVERR.
module axi2mem #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 32,
   parameter int AXI4_ID_WIDTH      = 16,
   parameter int AXI4_USER_WIDTH    = 10,
   parameter int MEM_ADDR_WIDTH     = 12
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   AXI_BUS.Slave                     AXI_Slave,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]                mem_be_o,
   output logic [31:0]               mem_wdata_o,
   input  logic [31:0]               mem_rdata_i
);
   localparam int AW = MEM_ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, READ_LATCH, READ_RESP, WRITE_RESP} state_e;

   state_e                   state_q, state_d;
   logic                     aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
   logic                     aw_bad_q, aw_bad_d, ar_bad_q, ar_bad_d;
   logic [AW-1:0]            aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
   logic [AXI4_ID_WIDTH-1:0] aw_id_q, aw_id_d, ar_id_q, ar_id_d, rsp_id_q, rsp_id_d;
   logic [31:0]              w_data_q, w_data_d, rdata_q, rdata_d;
   logic [3:0]               w_strb_q, w_strb_d;
   logic                     prio_q, prio_d;   // 1: write wins a tie
   logic                     err_q, err_d;
   logic                     aw_hs, w_hs, ar_hs, wr_pend, rd_pend;

   assign AXI_Slave.aw_ready = rst_ni & ~aw_full_q;
   assign AXI_Slave.w_ready  = rst_ni & ~w_full_q;
   assign AXI_Slave.ar_ready = rst_ni & ~ar_full_q;

   assign aw_hs = AXI_Slave.aw_valid & AXI_Slave.aw_ready;
   assign w_hs  = AXI_Slave.w_valid  & AXI_Slave.w_ready;
   assign ar_hs = AXI_Slave.ar_valid & AXI_Slave.ar_ready;

   logic unused_bits;
`ifdef AXI2MEM_ERR_CHECK_EN
   // Bad-request status is resolved at capture so only one bit is held.
   assign aw_bad_d = aw_hs ? ((AXI_Slave.aw_len != 8'd0) || (AXI_Slave.aw_size != 3'b010)) : aw_bad_q;
   assign ar_bad_d = ar_hs ? ((AXI_Slave.ar_len != 8'd0) || (AXI_Slave.ar_size != 3'b010)) : ar_bad_q;
   assign unused_bits = ^{AXI_Slave.aw_addr[AXI4_ADDRESS_WIDTH-1:AW+2], AXI_Slave.aw_addr[1:0],
                          AXI_Slave.ar_addr[AXI4_ADDRESS_WIDTH-1:AW+2], AXI_Slave.ar_addr[1:0],
                          AXI_Slave.w_last};
`else
   assign aw_bad_d = 1'b0;
   assign ar_bad_d = 1'b0;
   assign unused_bits = ^{AXI_Slave.aw_addr[AXI4_ADDRESS_WIDTH-1:AW+2], AXI_Slave.aw_addr[1:0],
                          AXI_Slave.ar_addr[AXI4_ADDRESS_WIDTH-1:AW+2], AXI_Slave.ar_addr[1:0],
                          AXI_Slave.w_last, AXI_Slave.aw_len, AXI_Slave.aw_size,
                          AXI_Slave.ar_len, AXI_Slave.ar_size};
`endif

   always_comb begin
      state_d     = state_q;
      aw_full_d   = aw_full_q | aw_hs;
      w_full_d    = w_full_q  | w_hs;
      ar_full_d   = ar_full_q | ar_hs;
      aw_addr_d   = aw_hs ? AXI_Slave.aw_addr[AW+1:2] : aw_addr_q;
      aw_id_d     = aw_hs ? AXI_Slave.aw_id : aw_id_q;
      ar_addr_d   = ar_hs ? AXI_Slave.ar_addr[AW+1:2] : ar_addr_q;
      ar_id_d     = ar_hs ? AXI_Slave.ar_id : ar_id_q;
      w_data_d    = w_hs ? AXI_Slave.w_data : w_data_q;
      w_strb_d    = w_hs ? AXI_Slave.w_strb : w_strb_q;
      rsp_id_d    = rsp_id_q;
      rdata_d     = rdata_q;
      prio_d      = prio_q;
      err_d       = err_q;
      wr_pend     = aw_full_q & w_full_q;
      rd_pend     = ar_full_q;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = aw_addr_q;
      mem_be_o    = w_strb_q;
      mem_wdata_o = w_data_q;
      unique case (state_q)
         IDLE: begin
            if (wr_pend && (!rd_pend || prio_q)) begin
               aw_full_d = 1'b0;
               w_full_d  = 1'b0;
               prio_d    = ~prio_q;
               rsp_id_d  = aw_id_q;
               err_d     = aw_bad_q;
               mem_req_o = ~aw_bad_q;
               mem_we_o  = ~aw_bad_q;
               state_d   = WRITE_RESP;
            end else if (rd_pend) begin
               ar_full_d  = 1'b0;
               prio_d     = ~prio_q;
               rsp_id_d   = ar_id_q;
               err_d      = ar_bad_q;
               mem_req_o  = ~ar_bad_q;
               mem_addr_o = ar_addr_q;
               // Errored reads skip the SRAM and answer with zero data.
               if (ar_bad_q) begin
                  rdata_d = '0;
                  state_d = READ_RESP;
               end else begin
                  state_d = READ_LATCH;
               end
            end
         end
         READ_LATCH: begin
            rdata_d = mem_rdata_i;
            state_d = READ_RESP;
         end
         READ_RESP:  if (AXI_Slave.r_ready) state_d = IDLE;
         WRITE_RESP: if (AXI_Slave.b_ready) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         ar_full_q <= 1'b0;
         aw_bad_q  <= 1'b0;
         ar_bad_q  <= 1'b0;
         aw_addr_q <= '0;
         ar_addr_q <= '0;
         aw_id_q   <= '0;
         ar_id_q   <= '0;
         rsp_id_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         rdata_q   <= '0;
         prio_q    <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         ar_full_q <= ar_full_d;
         aw_bad_q  <= aw_bad_d;
         ar_bad_q  <= ar_bad_d;
         aw_addr_q <= aw_addr_d;
         ar_addr_q <= ar_addr_d;
         aw_id_q   <= aw_id_d;
         ar_id_q   <= ar_id_d;
         rsp_id_q  <= rsp_id_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         rdata_q   <= rdata_d;
         prio_q    <= prio_d;
         err_q     <= err_d;
      end
   end

   assign AXI_Slave.r_valid = (state_q == READ_RESP);
   assign AXI_Slave.r_data  = rdata_q;
   assign AXI_Slave.r_id    = rsp_id_q;
   assign AXI_Slave.r_resp  = err_q ? 2'b10 : 2'b00;
   assign AXI_Slave.r_last  = 1'b1;
   assign AXI_Slave.r_user  = '0;
   assign AXI_Slave.b_valid = (state_q == WRITE_RESP);
   assign AXI_Slave.b_id    = rsp_id_q;
   assign AXI_Slave.b_resp  = err_q ? 2'b10 : 2'b00;
   assign AXI_Slave.b_user  = '0;
endmodule

// File: tb/tb_axi2mem.sv
// Scoreboard bench for axi2mem: stimulus pushes expected SRAM accesses and
// B/R responses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_axi2mem;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10)) axi ();

   logic        mem_req, mem_we;
   logic [11:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;

   axi2mem #(.AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(16),
             .AXI4_USER_WIDTH(10), .MEM_ADDR_WIDTH(12)) dut (
      .clk_i(clk), .rst_ni(rst_n), .AXI_Slave(axi),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   // SRAM model: byte-enabled writes, read data only in the cycle after the request
   logic [31:0] tbmem [0:4095];
   logic        pre_we = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [31:0] pre_data = '0;
   always @(posedge clk) begin
      mem_rdata <= 32'hBAD0BAD0;
      if (pre_we) tbmem[pre_addr] <= pre_data;
      if (mem_req && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) tbmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else if (mem_req) begin
         mem_rdata <= tbmem[mem_addr];
      end
   end

   typedef struct {logic we; logic [11:0] addr; logic [3:0] be; logic [31:0] wd; int c;} mexp_t;
   typedef struct {logic [31:0] data; logic [15:0] id; logic [1:0] resp; int c;} rexp_t;
   typedef struct {logic [15:0] id; logic [1:0] resp; int c;} bexp_t;
   mexp_t mq[$];
   rexp_t rq[$];
   bexp_t bq[$];

   task automatic push_m(input logic we, input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd, input int c);
      mexp_t e;
      e.we = we; e.addr = a; e.be = be; e.wd = wd; e.c = c;
      mq.push_back(e);
   endtask
   task automatic push_r(input logic [31:0] d, input logic [15:0] id, input logic [1:0] rs, input int c);
      rexp_t e;
      e.data = d; e.id = id; e.resp = rs; e.c = c;
      rq.push_back(e);
   endtask
   task automatic push_b(input logic [15:0] id, input logic [1:0] rs, input int c);
      bexp_t e;
      e.id = id; e.resp = rs; e.c = c;
      bq.push_back(e);
   endtask

   // Monitor: every presented output is compared with the queue head
   mexp_t m;
   logic r_prev = 1'b0, b_prev = 1'b0, r_wait = 1'b0, b_wait = 1'b0;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev = 1'b0; b_prev = 1'b0; r_wait = 1'b0; b_wait = 1'b0;
      end else begin
         if (mem_req) begin
            if (mq.size() == 0) begin
               checks++; failures++;
               $display("FAIL mem_unexpected: got req we=%0b addr=%0h, expected none (cycle %0d)", mem_we, mem_addr, cyc);
            end else begin
               m = mq.pop_front();
               chk("mem_we", mem_we, m.we);
               chk("mem_addr", mem_addr, m.addr);
               if (m.we) begin
                  chk("mem_be", mem_be, m.be);
                  chk("mem_wdata", mem_wdata, m.wd);
               end
               if (m.c >= 0) chk("mem_cycle", cyc, m.c);
            end
         end
         if (r_wait && !axi.r_valid) chk("r_valid_hold", axi.r_valid, 1);
         if (b_wait && !axi.b_valid) chk("b_valid_hold", axi.b_valid, 1);
         if (axi.r_valid) begin
            if (rq.size() == 0) begin
               checks++; failures++;
               $display("FAIL r_unexpected: got r_valid id=%0h, expected none (cycle %0d)", axi.r_id, cyc);
            end else begin
               chk("r_data", axi.r_data, rq[0].data);
               chk("r_id", axi.r_id, rq[0].id);
               chk("r_resp", axi.r_resp, rq[0].resp);
               chk("r_last", axi.r_last, 1);
               chk("r_user", axi.r_user, 0);
               if (!r_prev && rq[0].c >= 0) chk("r_cycle", cyc, rq[0].c);
               if (axi.r_ready) void'(rq.pop_front());
            end
         end
         if (axi.b_valid) begin
            if (bq.size() == 0) begin
               checks++; failures++;
               $display("FAIL b_unexpected: got b_valid id=%0h, expected none (cycle %0d)", axi.b_id, cyc);
            end else begin
               chk("b_id", axi.b_id, bq[0].id);
               chk("b_resp", axi.b_resp, bq[0].resp);
               chk("b_user", axi.b_user, 0);
               if (!b_prev && bq[0].c >= 0) chk("b_cycle", cyc, bq[0].c);
               if (axi.b_ready) void'(bq.pop_front());
            end
         end
         r_prev = axi.r_valid;
         b_prev = axi.b_valid;
         r_wait = axi.r_valid && !axi.r_ready;
         b_wait = axi.b_valid && !axi.b_ready;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Each sender returns the cycle whose closing edge completed the handshake
   task automatic send_aw(input logic [31:0] a, input logic [15:0] id, input logic [7:0] len, output int hs);
      axi.aw_addr = a; axi.aw_id = id; axi.aw_len = len; axi.aw_size = 3'b010; axi.aw_valid = 1'b1;
      hs = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (axi.aw_ready) begin hs = cyc; break; end
      end
      tick(1);
      axi.aw_valid = 1'b0;
      if (hs < 0) chk("aw_handshake_timeout", 0, 1);
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hs);
      axi.w_data = d; axi.w_strb = s; axi.w_last = 1'b1; axi.w_valid = 1'b1;
      hs = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (axi.w_ready) begin hs = cyc; break; end
      end
      tick(1);
      axi.w_valid = 1'b0;
      if (hs < 0) chk("w_handshake_timeout", 0, 1);
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [15:0] id, input logic [7:0] len, output int hs);
      axi.ar_addr = a; axi.ar_id = id; axi.ar_len = len; axi.ar_size = 3'b010; axi.ar_valid = 1'b1;
      hs = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (axi.ar_ready) begin hs = cyc; break; end
      end
      tick(1);
      axi.ar_valid = 1'b0;
      if (hs < 0) chk("ar_handshake_timeout", 0, 1);
   endtask

   task automatic wait_rvalid();
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (axi.r_valid) break;
      end
      if (i == 50) chk("r_valid_timeout", 0, 1);
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mq.size() == 0 && rq.size() == 0 && bq.size() == 0 && !axi.r_valid && !axi.b_valid) break;
      end
      chk("drain_pending", mq.size() + rq.size() + bq.size(), 0);
      tick(1);
   endtask

   task automatic check_idle_readys(input string tag);
      chk({tag, "_aw_ready"}, axi.aw_ready, 1);
      chk({tag, "_w_ready"},  axi.w_ready, 1);
      chk({tag, "_ar_ready"}, axi.ar_ready, 1);
      chk({tag, "_r_valid"},  axi.r_valid, 0);
      chk({tag, "_b_valid"},  axi.b_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int h1, h2, h3, h;
      rst_n = 1'b0;
      axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
      axi.aw_addr = '0; axi.aw_id = '0; axi.aw_len = '0; axi.aw_size = 3'b010;
      axi.ar_addr = '0; axi.ar_id = '0; axi.ar_len = '0; axi.ar_size = 3'b010;
      axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b1;
      axi.b_ready = 1'b1; axi.r_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_aw_ready", axi.aw_ready, 0);
      chk("rst_w_ready", axi.w_ready, 0);
      chk("rst_ar_ready", axi.ar_ready, 0);
      chk("rst_r_valid", axi.r_valid, 0);
      chk("rst_b_valid", axi.b_valid, 0);
      chk("rst_mem_req", mem_req, 0);
      rst_n = 1'b1;
      tick(1);
      check_idle_readys("post_rst");

      // AW and W in the same cycle; word 0x10>>2 = 0x4
      fork
         send_aw(32'h10, 16'h00A1, 8'd0, h1);
         send_w(32'hDEADBEEF, 4'hF, h2);
      join
      h = (h1 > h2) ? h1 : h2;
      push_m(1'b1, 12'h004, 4'hF, 32'hDEADBEEF, h + 1);
      push_b(16'h00A1, 2'b00, h + 2);
      drain();

      // W three cycles ahead of AW; aliased address 0xFFFFF008 -> word 0xC02
      send_w(32'h12345678, 4'h5, h2);
      tick(2);
      chk("w_held_ready", axi.w_ready, 0);
      send_aw(32'hFFFF_F008, 16'h0033, 8'd0, h1);
      push_m(1'b1, 12'hC02, 4'h5, 32'h12345678, h1 + 1);
      push_b(16'h0033, 2'b00, h1 + 2);
      drain();

      // Read with r_ready held low for 4 cycles
      pre_addr = 12'h004; pre_data = 32'hCAFEF00D; pre_we = 1'b1;
      tick(1);
      pre_we = 1'b0;
      axi.r_ready = 1'b0;
      send_ar(32'h10, 16'h0005, 8'd0, h3);
      push_m(1'b0, 12'h004, 4'h0, 32'h0, h3 + 1);
      push_r(32'hCAFEF00D, 16'h0005, 2'b00, h3 + 3);
      wait_rvalid();
      repeat (4) @(posedge clk);
      #1;
      axi.r_ready = 1'b1;
      drain();

      // Reset restores write priority, then two rounds of simultaneous AR + AW/W
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick(1);
      for (int k = 0; k < 2; k++) begin
         fork
            send_aw(32'h20, 16'h0040 + 16'(k), 8'd0, h1);
            send_w((k == 0) ? 32'h11111111 : 32'h22222222, (k == 0) ? 4'hF : 4'h3, h2);
            send_ar(32'h20, 16'h0050 + 16'(k), 8'd0, h3);
         join
         push_m(1'b1, 12'h008, (k == 0) ? 4'hF : 4'h3, (k == 0) ? 32'h11111111 : 32'h22222222, h1 + 1);
         push_b(16'h0040 + 16'(k), 2'b00, h1 + 2);
         push_m(1'b0, 12'h008, 4'h0, 32'h0, h1 + 3);
         push_r((k == 0) ? 32'h11111111 : 32'h11112222, 16'h0050 + 16'(k), 2'b00, h1 + 5);
         drain();
      end

      // Reset pulse while a read response is waiting
      axi.r_ready = 1'b0;
      send_ar(32'h10, 16'h0006, 8'd0, h3);
      push_m(1'b0, 12'h004, 4'h0, 32'h0, h3 + 1);
      push_r(32'hCAFEF00D, 16'h0006, 2'b00, h3 + 3);
      wait_rvalid();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_r_valid", axi.r_valid, 0);
      chk("mid_rst_ar_ready", axi.ar_ready, 0);
      chk("mid_rst_mem_req", mem_req, 0);
      rq.delete();
      #1;
      rst_n = 1'b1;
      tick(1);
      axi.r_ready = 1'b1;
      check_idle_readys("rst_release");

      // Read with ar_len=1
      send_ar(32'h20, 16'h0007, 8'd1, h3);
`ifdef AXI2MEM_ERR_CHECK_EN
      push_r(32'h0, 16'h0007, 2'b10, h3 + 2);
`else
      push_m(1'b0, 12'h008, 4'h0, 32'h0, h3 + 1);
      push_r(32'h11112222, 16'h0007, 2'b00, h3 + 3);
`endif
      drain();
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
